// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt/timer controller: FSM states, source
// indices, read-back field positions and the level priority helper.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } irq_state_t;

    localparam int NUM_SRC = 3;
    localparam int TMR     = 0;
    localparam int IRQ1    = 1;
    localparam int IRQ2    = 2;

    localparam int RD_MASK_LSB = 0;
    localparam int RD_PEND_LSB = 4;

    // Highest 68000 level among pending sources; 0 means nothing pending.
    function automatic logic [2:0] highest_level(input logic [2:0] pend,
                                                 input logic [2:0] lvl_tmr,
                                                 input logic [2:0] lvl_irq1,
                                                 input logic [2:0] lvl_irq2);
        logic [2:0] best;
        best = 3'd0;
        if (pend[TMR] && (lvl_tmr > best))
            best = lvl_tmr;
        if (pend[IRQ1] && (lvl_irq1 > best))
            best = lvl_irq1;
        if (pend[IRQ2] && (lvl_irq2 > best))
            best = lvl_irq2;
        return best;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for an asynchronous request, followed by a registered
// rising-edge detector producing a one-cycle pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // The pulse is registered so an input seen at edge N reaches pending at N+3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            rise      <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/irq_timer_ctrl.sv
// 68000 interrupt controller: periodic timer plus two external sources,
// encoded onto _ipl and acknowledged by autovector (_vpa) or bus error (_berr).
module irq_timer_ctrl
    import irq_pkg::*;
#(
    parameter int PRESCALE  = 32768,
    parameter int TIMER_LVL = 6,
    parameter int IRQ1_LVL  = 2,
    parameter int IRQ2_LVL  = 4
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       INTR1,
    input  logic       INTR2,
    input  logic       _as,
    input  logic [2:0] fc,
    input  logic [2:0] addr,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic [2:0] _ipl,
    output logic       _vpa,
    output logic       _berr
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    localparam logic [2:0] LVL_TMR  = 3'(TIMER_LVL);
    localparam logic [2:0] LVL_IRQ1 = 3'(IRQ1_LVL);
    localparam logic [2:0] LVL_IRQ2 = 3'(IRQ2_LVL);

    if ((TIMER_LVL < 1) || (TIMER_LVL > 7) || (IRQ1_LVL < 1) || (IRQ1_LVL > 7) ||
        (IRQ2_LVL < 1) || (IRQ2_LVL > 7) || (TIMER_LVL == IRQ1_LVL) ||
        (TIMER_LVL == IRQ2_LVL) || (IRQ1_LVL == IRQ2_LVL) || (PRESCALE < 1)) begin : g_bad_params
        $error("irq_timer_ctrl: levels must be distinct in 1..7 and PRESCALE >= 1");
    end

    logic [CW-1:0]    cnt;
    logic             tick;
    logic             rise1;
    logic             rise2;
    logic [2:0]       mask;
    logic [2:0]       pend;
    logic [2:0]       set_vec;
    logic [2:0]       clr_vec;
    logic [2:0]       eff_pend;
    logic [2:0]       ack_hit;
    logic [2:0]       ack_clr;
    logic             wr_clr_all;
    logic             as_seen_high;
    logic             iack_start;
    logic             vpa_next;
    logic             berr_next;
    logic [7:0]       rdata_next;
    irq_state_t       state;
    irq_state_t       state_next;
    logic             unused_wdata;

    assign unused_wdata = ^reg_wdata[6:3];

    irq_sync_edge u_sync_intr1 (
        .clk      (clk),
        .rst_n    (_rst),
        .async_in (INTR1),
        .rise     (rise1)
    );

    irq_sync_edge u_sync_intr2 (
        .clk      (clk),
        .rst_n    (_rst),
        .async_in (INTR2),
        .rise     (rise2)
    );

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign set_vec[TMR]  = tick  & mask[TMR];
    assign set_vec[IRQ1] = rise1 & mask[IRQ1];
    assign set_vec[IRQ2] = rise2 & mask[IRQ2];

    // A clearing bus write hides pending from the acknowledge, so it resolves as spurious.
    assign wr_clr_all = reg_wr & reg_wdata[7];
    assign eff_pend   = wr_clr_all ? 3'b000 : pend;

    assign ack_hit[TMR]  = eff_pend[TMR]  && (addr == LVL_TMR);
    assign ack_hit[IRQ1] = eff_pend[IRQ1] && (addr == LVL_IRQ1);
    assign ack_hit[IRQ2] = eff_pend[IRQ2] && (addr == LVL_IRQ2);

    assign clr_vec = wr_clr_all ? 3'b111 : ack_clr;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            mask <= '0;
            pend <= '0;
        end else begin
            if (reg_wr)
                mask <= reg_wdata[2:0];
            pend <= (pend & ~clr_vec) | set_vec;
        end
    end

    always_comb begin
        rdata_next = '0;
        rdata_next[RD_PEND_LSB +: NUM_SRC] = pend;
        rdata_next[RD_MASK_LSB +: NUM_SRC] = mask;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            reg_rdata <= '0;
            _ipl      <= 3'b111;
        end else begin
            if (reg_rd)
                reg_rdata <= rdata_next;
            _ipl <= ~highest_level(pend, LVL_TMR, LVL_IRQ1, LVL_IRQ2);
        end
    end

    // IACK must start with _as seen high, so a cycle still in flight across reset is ignored.
    assign iack_start = !_as && (fc == 3'b111) && as_seen_high;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state        <= ST_IDLE;
            as_seen_high <= 1'b0;
            _vpa         <= 1'b1;
            _berr        <= 1'b1;
        end else begin
            state        <= state_next;
            as_seen_high <= _as;
            _vpa         <= vpa_next;
            _berr        <= berr_next;
        end
    end

    always_comb begin
        state_next = state;
        vpa_next   = 1'b1;
        berr_next  = 1'b1;
        ack_clr    = '0;
        unique case (state)
            ST_IDLE: begin
                if (iack_start)
                    state_next = ST_ACK;
            end
            ST_ACK: begin
                if (|ack_hit) begin
                    vpa_next = 1'b0;
                    ack_clr  = ack_hit;
                end else begin
                    berr_next = 1'b0;
                end
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (_as) begin
                    state_next = ST_IDLE;
                end else begin
                    vpa_next  = _vpa;
                    berr_next = _berr;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Scoreboard bench for irq_timer_ctrl: directed phases queue expected outputs,
// a negedge monitor pops and compares them at their due cycle.
module tb_irq_timer_ctrl;

    localparam int PRESCALE = 8;

    logic       clk;
    logic       _rst;
    logic       INTR1;
    logic       INTR2;
    logic       _as;
    logic [2:0] fc;
    logic [2:0] addr;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [2:0] _ipl;
    logic       _vpa;
    logic       _berr;

    typedef enum int {K_IPL, K_VPA, K_BERR, K_RDATA} kind_t;
    typedef enum int {OP_WR, OP_RD, OP_I1_HI, OP_I1_LO, OP_I2_HI, OP_I2_LO, OP_IACK, OP_AS_HI} op_t;

    typedef struct {
        string      name;
        kind_t      kind;
        int         due;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];

    int cyc       = 0;
    int base      = 0;
    int checks    = 0;
    int passed    = 0;
    int both_low  = 0;
    int done_cyc  = 0;
    bit stim_done = 1'b0;

    irq_timer_ctrl #(
        .PRESCALE  (PRESCALE),
        .TIMER_LVL (6),
        .IRQ1_LVL  (2),
        .IRQ2_LVL  (4)
    ) dut (
        .clk       (clk),
        ._rst      (_rst),
        .INTR1     (INTR1),
        .INTR2     (INTR2),
        ._as       (_as),
        .fc        (fc),
        .addr      (addr),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        ._ipl      (_ipl),
        ._vpa      (_vpa),
        ._berr     (_berr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Move to just after edge base+rel; one-cycle strobes drop on every advance.
    task automatic advanceTo(input int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
            reg_wr = 1'b0;
            reg_rd = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int rel, input op_t op, input logic [7:0] val);
        advanceTo(rel);
        case (op)
            OP_WR:    begin reg_wr = 1'b1; reg_wdata = val; end
            OP_RD:    reg_rd = 1'b1;
            OP_I1_HI: INTR1 = 1'b1;
            OP_I1_LO: INTR1 = 1'b0;
            OP_I2_HI: INTR2 = 1'b1;
            OP_I2_LO: INTR2 = 1'b0;
            OP_IACK:  begin _as = 1'b0; fc = 3'b111; addr = val[2:0]; end
            OP_AS_HI: begin _as = 1'b1; fc = 3'b000; end
            default:  ;
        endcase
    endtask

    task automatic checkOutput(input int rel, input kind_t kind, input logic [7:0] val, input string name);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.due  = base + rel;
        e.exp  = val;
        sb_q.push_back(e);
    endtask

    // Reset is asserted between edges, so the values checked at the next negedge prove it is immediate.
    task automatic doReset(input bit keep_bus);
        @(posedge clk);
        #1;
        _rst   = 1'b0;
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        INTR1  = 1'b0;
        INTR2  = 1'b0;
        if (!keep_bus) begin
            _as  = 1'b1;
            fc   = 3'b000;
            addr = 3'b000;
        end
        base = cyc;
        checkOutput(0, K_IPL,   8'h07, "rst_ipl");
        checkOutput(0, K_VPA,   8'h01, "rst_vpa");
        checkOutput(0, K_BERR,  8'h01, "rst_berr");
        checkOutput(0, K_RDATA, 8'h00, "rst_rdata");
        repeat (3) @(posedge clk);
        #1;
        _rst = 1'b1;
        base = cyc;
    endtask

    always @(negedge clk) begin
        int         idx;
        logic [7:0] act;
        if (_vpa === 1'b0 && _berr === 1'b0)
            both_low++;
        idx = 0;
        while (idx < sb_q.size()) begin
            if (sb_q[idx].due <= cyc) begin
                case (sb_q[idx].kind)
                    K_IPL:   act = {5'b0, _ipl};
                    K_VPA:   act = {7'b0, _vpa};
                    K_BERR:  act = {7'b0, _berr};
                    default: act = reg_rdata;
                endcase
                checks++;
                if (sb_q[idx].due < cyc)
                    $display("[TB] FAIL %s: missed due cycle %0d (now %0d)", sb_q[idx].name, sb_q[idx].due, cyc);
                else if (act !== sb_q[idx].exp)
                    $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at cycle %0d",
                             sb_q[idx].name, act, sb_q[idx].exp, cyc);
                else
                    passed++;
                sb_q.delete(idx);
            end else begin
                idx++;
            end
        end
        if (stim_done && (sb_q.size() == 0 || cyc > done_cyc + 50)) begin
            while (sb_q.size() > 0) begin
                checks++;
                $display("[TB] FAIL %s: never compared, expected 0x%02h", sb_q[0].name, sb_q[0].exp);
                sb_q.delete(0);
            end
            checks++;
            if (both_low != 0)
                $display("[TB] FAIL vpa_berr_exclusive: both low in %0d cycles, required 0", both_low);
            else
                passed++;
            $display("%0d/%0d checks passed", passed, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        _rst      = 1'b1;
        INTR1     = 1'b0;
        INTR2     = 1'b0;
        _as       = 1'b1;
        fc        = 3'b000;
        addr      = 3'b000;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_wdata = 8'h00;

        $display("[TB] INTR1 with all sources enabled, autovector ack of level 2");
        doReset(1'b0);
        checkOutput(4,  K_IPL,   8'h07, "b_ipl_n3");
        checkOutput(5,  K_IPL,   8'h05, "b_ipl_n4");
        checkOutput(6,  K_VPA,   8'h01, "b_vpa_pre");
        checkOutput(7,  K_VPA,   8'h00, "b_vpa_ack");
        checkOutput(7,  K_BERR,  8'h01, "b_berr_idle");
        checkOutput(8,  K_IPL,   8'h07, "b_ipl_clr");
        checkOutput(9,  K_VPA,   8'h00, "b_vpa_hold");
        checkOutput(9,  K_IPL,   8'h01, "b_ipl_tmr");
        checkOutput(10, K_VPA,   8'h01, "b_vpa_rel");
        checkOutput(11, K_RDATA, 8'h17, "b_rdata");
        applyStimulus(0,  OP_WR,    8'h07);
        applyStimulus(0,  OP_I1_HI, 8'h00);
        applyStimulus(3,  OP_I1_LO, 8'h00);
        applyStimulus(5,  OP_IACK,  8'h02);
        applyStimulus(9,  OP_AS_HI, 8'h00);
        applyStimulus(10, OP_RD,    8'h00);
        advanceTo(12);

        $display("[TB] timer ticks, write-clear and masking");
        doReset(1'b0);
        checkOutput(8,  K_IPL,   8'h07, "c_ipl_pre");
        checkOutput(9,  K_IPL,   8'h01, "c_ipl_tick");
        checkOutput(10, K_RDATA, 8'h11, "c_rdata");
        checkOutput(17, K_IPL,   8'h01, "c_ipl_tick2");
        checkOutput(18, K_IPL,   8'h01, "c_ipl_preclr");
        checkOutput(19, K_IPL,   8'h07, "c_ipl_wrclr");
        checkOutput(25, K_IPL,   8'h07, "c_ipl_masked");
        applyStimulus(0,  OP_WR, 8'h01);
        applyStimulus(9,  OP_RD, 8'h00);
        applyStimulus(17, OP_WR, 8'h81);
        applyStimulus(19, OP_WR, 8'h00);
        advanceTo(26);

        $display("[TB] timer and INTR2 together, ack level 6, mask keeps pending");
        doReset(1'b0);
        checkOutput(5,  K_IPL,   8'h03, "d_ipl_irq2");
        checkOutput(9,  K_IPL,   8'h01, "d_ipl_both");
        checkOutput(11, K_VPA,   8'h00, "d_vpa_ack");
        checkOutput(11, K_IPL,   8'h01, "d_ipl_atclr");
        checkOutput(12, K_IPL,   8'h03, "d_ipl_after");
        checkOutput(13, K_VPA,   8'h01, "d_vpa_rel");
        checkOutput(17, K_IPL,   8'h03, "d_ipl_masked");
        checkOutput(18, K_RDATA, 8'h40, "d_rdata");
        applyStimulus(0,  OP_WR,    8'h05);
        applyStimulus(0,  OP_I2_HI, 8'h00);
        applyStimulus(9,  OP_IACK,  8'h06);
        applyStimulus(12, OP_AS_HI, 8'h00);
        applyStimulus(13, OP_WR,    8'h00);
        applyStimulus(17, OP_RD,    8'h00);
        applyStimulus(18, OP_I2_LO, 8'h00);
        advanceTo(19);

        $display("[TB] spurious ack of level 3");
        doReset(1'b0);
        checkOutput(6, K_BERR,  8'h01, "e_berr_pre");
        checkOutput(7, K_BERR,  8'h00, "e_berr_ack");
        checkOutput(7, K_VPA,   8'h01, "e_vpa_ack");
        checkOutput(8, K_BERR,  8'h01, "e_berr_rel");
        checkOutput(9, K_RDATA, 8'h44, "e_rdata");
        checkOutput(9, K_IPL,   8'h03, "e_ipl");
        applyStimulus(0, OP_WR,    8'h04);
        applyStimulus(0, OP_I2_HI, 8'h00);
        applyStimulus(5, OP_IACK,  8'h03);
        applyStimulus(7, OP_AS_HI, 8'h00);
        applyStimulus(8, OP_RD,    8'h00);
        applyStimulus(9, OP_I2_LO, 8'h00);
        advanceTo(10);

        $display("[TB] INTR1 edge coincident with its ack clear");
        doReset(1'b0);
        checkOutput(5, K_IPL,   8'h05, "f_ipl_first");
        checkOutput(7, K_VPA,   8'h00, "f_vpa_ack");
        checkOutput(8, K_RDATA, 8'h22, "f_rdata");
        checkOutput(8, K_IPL,   8'h05, "f_ipl_kept");
        checkOutput(9, K_VPA,   8'h01, "f_vpa_rel");
        applyStimulus(0, OP_WR,    8'h02);
        applyStimulus(0, OP_I1_HI, 8'h00);
        applyStimulus(2, OP_I1_LO, 8'h00);
        applyStimulus(3, OP_I1_HI, 8'h00);
        applyStimulus(5, OP_IACK,  8'h02);
        applyStimulus(7, OP_RD,    8'h00);
        applyStimulus(8, OP_AS_HI, 8'h00);
        applyStimulus(9, OP_I1_LO, 8'h00);
        advanceTo(10);

        $display("[TB] clearing write during ACK");
        doReset(1'b0);
        checkOutput(5, K_IPL,   8'h05, "g_ipl_pend");
        checkOutput(7, K_BERR,  8'h00, "g_berr_ack");
        checkOutput(7, K_VPA,   8'h01, "g_vpa_ack");
        checkOutput(8, K_IPL,   8'h07, "g_ipl_clr");
        checkOutput(8, K_BERR,  8'h01, "g_berr_rel");
        checkOutput(9, K_RDATA, 8'h02, "g_rdata");
        applyStimulus(0, OP_WR,    8'h02);
        applyStimulus(0, OP_I1_HI, 8'h00);
        applyStimulus(3, OP_I1_LO, 8'h00);
        applyStimulus(5, OP_IACK,  8'h02);
        applyStimulus(6, OP_WR,    8'h82);
        applyStimulus(7, OP_AS_HI, 8'h00);
        applyStimulus(8, OP_RD,    8'h00);
        advanceTo(10);

        $display("[TB] reset during RELEASE with _as still low");
        doReset(1'b0);
        checkOutput(7, K_VPA, 8'h00, "h_vpa_ack");
        applyStimulus(0, OP_WR,    8'h02);
        applyStimulus(0, OP_I1_HI, 8'h00);
        applyStimulus(3, OP_I1_LO, 8'h00);
        applyStimulus(5, OP_IACK,  8'h02);
        advanceTo(8);
        doReset(1'b1);
        checkOutput(1, K_VPA,  8'h01, "h_vpa_post1");
        checkOutput(2, K_VPA,  8'h01, "h_vpa_post2");
        checkOutput(2, K_BERR, 8'h01, "h_berr_post2");
        checkOutput(3, K_VPA,  8'h01, "h_vpa_post3");
        checkOutput(3, K_BERR, 8'h01, "h_berr_post3");
        checkOutput(6, K_BERR, 8'h00, "h_berr_new");
        checkOutput(6, K_VPA,  8'h01, "h_vpa_new");
        checkOutput(7, K_BERR, 8'h01, "h_berr_rel");
        applyStimulus(3, OP_AS_HI, 8'h00);
        applyStimulus(4, OP_IACK,  8'h05);
        applyStimulus(6, OP_AS_HI, 8'h00);
        advanceTo(8);

        done_cyc  = cyc;
        stim_done = 1'b1;
    end

endmodule

// File: doc/irq_timer_ctrl.md
IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

Interface
REQ-001 Parameter PRESCALE, default 32768, timer period in clk cycles (about 92 Hz at 3 MHz).
REQ-002 Parameter TIMER_LVL, default 6, 68000 interrupt level of the timer source.
REQ-003 Parameter IRQ1_LVL, default 2, level of the INTR1 source; parameter IRQ2_LVL, default 4, level of the INTR2 source; all three levels SHALL be distinct and in 1..7.
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 _rst  in  1  asynchronous, active-low reset.
REQ-006 INTR1, INTR2  in  1 each  asynchronous external interrupt requests, active high.
REQ-007 _as  in  1  68000 address strobe, active low.
REQ-008 fc  in  3  68000 function code.
REQ-009 addr  in  3  68000 A3..A1; carries the acknowledged level during IACK.
REQ-010 reg_wr, reg_rd  in  1 each  one-cycle strobes from the glue decoder.
REQ-011 reg_wdata  in  8  write data; reg_rdata  out  8  read data.
REQ-012 _ipl  out  3  encoded interrupt level to the CPU, active low.
REQ-013 _vpa  out  1  autovector acknowledge, active low.
REQ-014 _berr  out  1  spurious-interrupt bus error, active low.

Function
REQ-015 INTR1 and INTR2 SHALL each pass through a 2-flop synchronizer; a 0->1 transition at the synchronizer output SHALL set that source's pending bit on the next edge.
REQ-016 Counter: 0..PRESCALE-1, free-running, wraps to 0; the wrap cycle SHALL produce a one-cycle tick that sets timer pending.
REQ-017 Mask register, 3 bits: bit0 timer, bit1 INTR1, bit2 INTR2. A pending bit SHALL set only when its mask bit is 1.
REQ-018 reg_wr SHALL load mask from reg_wdata[2:0]; when reg_wdata[7]=1, the same write SHALL also clear all pending bits.
REQ-019 reg_rdata SHALL be {1'b0, pend[2:0], 1'b0, mask[2:0]} with pend in mask bit order, registered on reg_rd, and holding otherwise.
REQ-020 _ipl SHALL be the bitwise inverse of the highest level among pending sources, or 3'b111 if none; it is registered, so it updates 1 cycle after pending changes.
REQ-021 Latency: an INTR input high at edge N SHALL give pending set at edge N+3 and _ipl valid at edge N+4.
REQ-022 IACK is detected when _as=0 and fc=3'b111, sampled on clk.
REQ-023 FSM states: IDLE, ACK, RELEASE.
- IDLE->ACK on IACK detect.
- In ACK: if addr matches a pending source level, assert _vpa=0 and clear that pending bit; otherwise assert _berr=0. Either way, go to RELEASE.
- RELEASE holds the asserted strobe until _as=1 is sampled, then deasserts it and returns to IDLE.
REQ-024 A set event and a clear of the same pending bit in the same cycle: set SHALL win.
REQ-025 A bus write that clears pending during ACK SHALL take priority; the ACK then resolves as no-match and asserts _berr.
REQ-026 _vpa and _berr SHALL never be low at the same time, and SHALL never assert outside an IACK cycle.
REQ-027 Masking a source SHALL not clear its pending bit; it only blocks new sets.

Reset
REQ-028 While _rst=0, all of the following SHALL hold immediately, without waiting for a clk edge:
- _ipl=3'b111, _vpa=1, _berr=1, reg_rdata=0.
- mask=0, pending=0, counter=0, synchronizers=0, FSM=IDLE.
REQ-029 Reset asserted mid-IACK SHALL drop _vpa/_berr at once; after release the FSM starts in IDLE, even if _as is still low.

Structure
REQ-030 Shared package irq_pkg SHALL hold the FSM state enum, the source index constants (TMR=0, IRQ1=1, IRQ2=2) and the reg_rdata field positions.
REQ-031 The block SHALL contain one sub-module, irq_sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated twice.

Verification
REQ-032 Write 0x07, then pulse INTR1 for 3 cycles -> _ipl=3'b101 at edge N+4; IACK with addr=2 -> _vpa low until _as high; pend bit1 cleared.
REQ-033 PRESCALE=8, mask=0x01 -> tick on cycle 8, _ipl=3'b001; a second tick before IACK does not change _ipl.
REQ-034 Timer and INTR2 pending together -> _ipl=3'b001; ack level 6 -> _ipl becomes 3'b011 one cycle after the clear.
REQ-035 IACK with addr=3 and no level-3 source -> _berr low, _vpa high, pending unchanged.
REQ-036 INTR1 edge in the same cycle as the IACK clear of INTR1 -> pend bit1 stays 1.
REQ-037 _rst low during RELEASE with _as low -> outputs inactive immediately; after reset no _vpa/_berr until a new IACK.
